cdc_bus_rx_mc: RTL and testbench
================================

CDC_BUS_RX_MC -- requirements
Module: cdc_bus_rx_mc

Interface
REQ-001 SHALL have parameter pDATA_WIDTH, default 8: data bits per channel.
REQ-002 SHALL have parameter pCHANNELS, default 4: number of independent asynchronous senders, range 1-16.
REQ-003 SHALL have parameter pSYNC_STAGES, default 2: synchroniser flops per request line, minimum 2.
REQ-004 SHALL have parameter pFIFO_DEPTH, default 8: output FIFO entries, power of two, minimum 2.
REQ-005 SHALL use one clock and an asynchronous active-high reset: dst_clk input 1, the only clock; reset_i input 1, asynchronous active-high reset.
REQ-006 SHALL have port async_req_i, input, pCHANNELS: per-channel 4-phase request, asynchronous to dst_clk.
REQ-007 SHALL have port async_data_i, input, pCHANNELS*pDATA_WIDTH: channel n data at [n*pDATA_WIDTH +: pDATA_WIDTH], stable while async_req_i[n] high.
REQ-008 SHALL have port ack_o, output, pCHANNELS: per-channel 4-phase acknowledge, registered.
REQ-009 SHALL have port out_valid, output, 1: FIFO head valid.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts head.
REQ-011 SHALL have port out_data, output, pDATA_WIDTH: head data.
REQ-012 SHALL have port out_chan, output, CW = max(1, clog2(pCHANNELS)): head source channel.
REQ-013 SHALL have port fifo_count, output, clog2(pFIFO_DEPTH)+1: current occupancy.

Function
REQ-014 SHALL synchronise each async_req_i bit through pSYNC_STAGES ASYNC_REG flops; req_s[n] is the last stage.
REQ-015 SHALL never synchronise async_data_i; data SHALL be sampled only in the grant cycle (REQ-018).
REQ-016 SHALL run a per-channel FSM with states IDLE, PEND, ACK.
REQ-017 SHALL move a channel IDLE->PEND on the clock where req_s[n]=1.
REQ-018 SHALL grant at most one PEND channel per cycle, and only when the FIFO can accept a write (count<pFIFO_DEPTH, or count=pFIFO_DEPTH with a pop in the same cycle). Grant writes {n, data_n} and moves the channel PEND->ACK. ack_o[n] rises on the same edge.
REQ-019 SHALL move a channel ACK->IDLE and clear ack_o[n] on the clock where req_s[n]=0.
REQ-020 SHALL arbitrate round-robin: search starts at (last granted+1) mod pCHANNELS; pointer resets to channel 0.
REQ-021 SHALL leave a PEND channel waiting indefinitely while the FIFO is full; no data loss, no overflow, ack withheld.
REQ-022 SHALL implement a first-word-fall-through FIFO: out_valid=1 the cycle after the first write into empty; pop when out_valid&out_ready.
REQ-023 SHALL support simultaneous push and pop, including when full (count unchanged) and when empty with no pop-through (out_valid next cycle).
REQ-024 SHALL wrap read/write pointers modulo pFIFO_DEPTH and keep fifo_count exact at wrap.
REQ-025 SHALL hold out_data/out_chan stable while out_valid=1 and out_ready=0.
REQ-026 SHALL give minimum latency async_req_i rise -> ack_o rise of pSYNC_STAGES+1 dst_clk edges, with an empty FIFO and no contention.
REQ-027 SHALL NOT set ack_o[n] for a channel whose req_s[n] was seen low in PEND; req withdrawn before grant returns PEND->IDLE, with no write.

Reset
REQ-028 SHALL, on reset_i, immediately clear all synchroniser flops, FSMs (IDLE), ack_o=0, out_valid=0, fifo_count=0, pointers=0, and arbiter pointer=0.
REQ-029 SHALL discard FIFO contents on reset mid-operation; a sender still holding req high after release SHALL be re-accepted as a new transfer (duplicate permitted, documented).

Verification
REQ-030 SHALL pass single transfer: pSYNC_STAGES=2, ch2 req=1 data=0xA5, FIFO empty -> ack_o[2]=1 after 3 edges; out_valid=1, out_data=0xA5, out_chan=2 next cycle; req=0 -> ack_o[2]=0 after 2-3 edges.
REQ-031 SHALL pass round-robin: ch0..ch3 raise req in the same cycle with data 0x10..0x13 -> FIFO order ch0,ch1,ch2,ch3, one grant per cycle; next simultaneous burst after last grant ch3 starts at ch0.
REQ-032 SHALL pass backpressure: out_ready=0, 9 transfers with depth 8 -> fifo_count=8, 9th ack withheld; one pop -> 9th granted next cycle, no loss, order preserved.
REQ-033 SHALL pass full push+pop: count=8, pop and pending grant in the same cycle -> count stays 8, head advances, new entry at tail.
REQ-034 SHALL pass reset mid-transfer: assert reset_i while ch1 in ACK with 3 FIFO entries -> ack_o=0, out_valid=0, count=0 asynchronously; release with ch1 req still high -> ch1 re-accepted once.
REQ-035 SHALL pass withdrawn request: ch3 req pulses high 3 cycles while FIFO full -> no FIFO write, ack_o[3] never rises.

Source files
------------

// File: rtl/cdc_bus_rx_mc.sv
// Multi-channel 4-phase handshake receiver. Each asynchronous sender's request is
// synchronised into dst_clk, arbitrated round-robin, and its data captured into a
// first-word-fall-through FIFO tagged with the source channel.
module cdc_bus_rx_mc #(
  parameter int unsigned  pDATA_WIDTH  = 8,
  parameter int unsigned  pCHANNELS    = 4,
  parameter int unsigned  pSYNC_STAGES = 2,
  parameter int unsigned  pFIFO_DEPTH  = 8,
  localparam int unsigned CW           = (pCHANNELS > 1) ? $clog2(pCHANNELS) : 1,
  localparam int unsigned AW           = $clog2(pFIFO_DEPTH)
) (
  input  logic                           dst_clk,
  input  logic                           reset_i,
  input  logic [pCHANNELS-1:0]           async_req_i,
  input  logic [pCHANNELS*pDATA_WIDTH-1:0] async_data_i,
  output logic [pCHANNELS-1:0]           ack_o,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [pDATA_WIDTH-1:0]         out_data,
  output logic [CW-1:0]                  out_chan,
  output logic [AW:0]                    fifo_count
);

  localparam int unsigned EW      = CW + pDATA_WIDTH;
  localparam int unsigned LastInt = pCHANNELS - 1;
  localparam logic [CW-1:0] LastChan  = LastInt[CW-1:0];
  localparam logic [AW:0]   FullCount = pFIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {StIdle, StPend, StAck} chan_state_e;

  (* ASYNC_REG = "TRUE" *) logic [pCHANNELS-1:0] sync_q [pSYNC_STAGES];

  logic [pCHANNELS-1:0]   req_s;
  logic [pCHANNELS-1:0]   eligible;
  chan_state_e            state_q [pCHANNELS];
  chan_state_e            state_d [pCHANNELS];
  logic [pCHANNELS-1:0]   ack_q;
  logic [CW-1:0]          rr_ptr_q, rr_ptr_d, grant_idx;
  logic                   grant_vld, do_grant, pop;
  logic [pDATA_WIDTH-1:0] grant_data;
  int                     cand;
  logic [EW-1:0]          mem_q [pFIFO_DEPTH];
  logic [EW-1:0]          head;
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [AW:0]            count_q;

  assign req_s = sync_q[pSYNC_STAGES-1];

  // Request synchronisers; only the request lines cross, data is sampled at grant.
  always_ff @(posedge dst_clk or posedge reset_i) begin
    if (reset_i) begin
      for (int s = 0; s < int'(pSYNC_STAGES); s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= async_req_i;
      for (int s = 1; s < int'(pSYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // A channel competes as soon as its synchronised request is seen, so an idle
  // channel can be granted on the same edge it would otherwise enter PEND.
  always_comb begin
    for (int n = 0; n < int'(pCHANNELS); n++) begin
      eligible[n] = req_s[n] && (state_q[n] != StAck);
    end
  end

  // Round-robin search starting at the pointer (one past the last grant).
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int i = 0; i < int'(pCHANNELS); i++) begin
      cand = (int'(rr_ptr_q) + i) % int'(pCHANNELS);
      if (!grant_vld && eligible[cand[CW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[CW-1:0];
      end
    end
    rr_ptr_d = (grant_idx == LastChan) ? '0 : grant_idx + 1'b1;
  end

  // Grant only when the FIFO has room, counting a pop on the same edge as room.
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign do_grant  = grant_vld && ((count_q != FullCount) || pop);

  // Data of the granted channel; its request is high so the bus is stable.
  always_comb begin
    grant_data = '0;
    for (int n = 0; n < int'(pCHANNELS); n++) begin
      if (grant_idx == n[CW-1:0]) grant_data = async_data_i[n*pDATA_WIDTH +: pDATA_WIDTH];
    end
  end

  // Per-channel handshake next state.
  always_comb begin
    for (int n = 0; n < int'(pCHANNELS); n++) begin
      state_d[n] = state_q[n];
      case (state_q[n])
        StIdle, StPend: begin
          if (!req_s[n]) begin
            state_d[n] = StIdle;
          end else if (do_grant && (grant_idx == n[CW-1:0])) begin
            state_d[n] = StAck;
          end else begin
            state_d[n] = StPend;
          end
        end
        StAck:   if (!req_s[n]) state_d[n] = StIdle;
        default: state_d[n] = StIdle;
      endcase
    end
  end

  // Channel state, registered acknowledge and arbiter pointer.
  always_ff @(posedge dst_clk or posedge reset_i) begin
    if (reset_i) begin
      for (int n = 0; n < int'(pCHANNELS); n++) state_q[n] <= StIdle;
      ack_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      for (int n = 0; n < int'(pCHANNELS); n++) begin
        state_q[n] <= state_d[n];
        ack_q[n]   <= (state_d[n] == StAck);
      end
      if (do_grant) rr_ptr_q <= rr_ptr_d;
    end
  end

  // FIFO storage; contents are don't-care after reset since count gates validity.
  always_ff @(posedge dst_clk) begin
    if (do_grant) mem_q[wr_ptr_q] <= {grant_idx, grant_data};
  end

  // FIFO pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge dst_clk or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_grant) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)      rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_grant && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (!do_grant && pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign out_data   = head[pDATA_WIDTH-1:0];
  assign out_chan   = head[EW-1:pDATA_WIDTH];
  assign ack_o      = ack_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_cdc_bus_rx_mc.sv
// Testbench for cdc_bus_rx_mc: directed scenarios plus a randomized multi-sender run
// checked against a transaction-level scoreboard.
module tb_cdc_bus_rx_mc;
  localparam int DW    = 8;
  localparam int NCH   = 4;
  localparam int SYNC  = 2;
  localparam int DEPTH = 8;
  localparam int CW    = 2;

  logic              dst_clk = 1'b0;
  logic              reset_i;
  logic [NCH-1:0]    async_req_i;
  logic [NCH*DW-1:0] async_data_i;
  logic [NCH-1:0]    ack_o;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [CW-1:0]     out_chan;
  logic [3:0]        fifo_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] d;
  } item_t;
  item_t exp_q[$];

  cdc_bus_rx_mc #(
    .pDATA_WIDTH (DW),
    .pCHANNELS   (NCH),
    .pSYNC_STAGES(SYNC),
    .pFIFO_DEPTH (DEPTH)
  ) dut (
    .dst_clk     (dst_clk),
    .reset_i     (reset_i),
    .async_req_i (async_req_i),
    .async_data_i(async_data_i),
    .ack_o       (ack_o),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_chan    (out_chan),
    .fifo_count  (fifo_count)
  );

  always #5 dst_clk = ~dst_clk;

  task automatic tick();
    @(posedge dst_clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i      = 1'b1;
    async_req_i  = '0;
    async_data_i = '0;
    out_ready    = 1'b0;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  task automatic set_data(input int ch, input logic [7:0] d);
    async_data_i[ch*DW +: DW] = d;
  endtask

  // Full 4-phase transfer on one channel; ok=0 if either handshake phase times out.
  task automatic xfer(input int ch, input logic [7:0] d, output bit ok);
    int k;
    ok = 1'b1;
    set_data(ch, d);
    async_req_i[ch] = 1'b1;
    k = 0;
    while (!ack_o[ch] && k < 20) begin tick(); k++; end
    if (!ack_o[ch]) ok = 1'b0;
    async_req_i[ch] = 1'b0;
    k = 0;
    while (ack_o[ch] && k < 20) begin tick(); k++; end
    if (ack_o[ch]) ok = 1'b0;
  endtask

  task automatic test_reset();
    reset_i      = 1'b1;
    async_req_i  = '0;
    async_data_i = '0;
    out_ready    = 1'b0;
    #2;
    checks++;
    if (ack_o !== 4'b0 || out_valid !== 1'b0 || fifo_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_async: ack=%b valid=%b count=%0d expected 0/0/0",
               ack_o, out_valid, fifo_count);
    end
    tick();
    reset_i = 1'b0;
    tick();
    tick();
    checks++;
    if (ack_o !== 4'b0 || out_valid !== 1'b0 || fifo_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_idle: ack=%b valid=%b count=%0d expected 0/0/0",
               ack_o, out_valid, fifo_count);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_data(2, 8'hA5);
    async_req_i[2] = 1'b1;
    tick();
    tick();
    checks++;
    if (ack_o !== 4'b0000) begin
      errors++;
      $display("FAIL single_ack_early: ack=%b expected 0000", ack_o);
    end
    tick();
    checks++;
    if (ack_o !== 4'b0100) begin
      errors++;
      $display("FAIL single_ack_rise: ack=%b expected 0100", ack_o);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_chan !== 2'd2) begin
      errors++;
      $display("FAIL single_head: valid=%b data=%h chan=%0d expected 1/a5/2",
               out_valid, out_data, out_chan);
    end
    async_req_i[2] = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (ack_o !== 4'b0000) begin
      errors++;
      $display("FAIL single_ack_fall: ack=%b expected 0000", ack_o);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (fifo_count !== 4'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pop: count=%0d valid=%b expected 0/0", fifo_count, out_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ack;
    logic [7:0] base;
    do_reset();
    for (int burst = 0; burst < 2; burst++) begin
      base = (burst == 0) ? 8'h10 : 8'h20;
      for (int i = 0; i < NCH; i++) set_data(i, base + 8'(i));
      async_req_i = 4'hF;
      tick();
      tick();
      for (int g = 0; g < NCH; g++) begin
        tick();
        exp_ack = 4'((1 << (g + 1)) - 1);
        checks++;
        if (ack_o !== exp_ack) begin
          errors++;
          $display("FAIL rr_grant burst%0d step%0d: ack=%b expected %b", burst, g, ack_o, exp_ack);
        end
      end
      for (int k = 0; k < NCH; k++) begin
        checks++;
        if (out_valid !== 1'b1 || out_chan !== 2'(k) || out_data !== base + 8'(k)) begin
          errors++;
          $display("FAIL rr_order burst%0d pos%0d: valid=%b chan=%0d data=%h expected 1/%0d/%h",
                   burst, k, out_valid, out_chan, out_data, k, base + 8'(k));
        end
        out_ready = 1'b1;
        tick();
      end
      out_ready   = 1'b0;
      async_req_i = '0;
      tick();
      tick();
      tick();
      checks++;
      if (ack_o !== 4'b0 || fifo_count !== 4'd0) begin
        errors++;
        $display("FAIL rr_release burst%0d: ack=%b count=%0d expected 0000/0", burst, ack_o,
                 fifo_count);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      xfer(i % NCH, 8'h40 + 8'(i), ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL bp_fill%0d: handshake timed out, expected complete", i);
      end
    end
    set_data(0, 8'h48);
    async_req_i[0] = 1'b1;
    repeat (10) tick();
    checks++;
    if (ack_o[0] !== 1'b0 || fifo_count !== 4'd8 || out_data !== 8'h40 || out_chan !== 2'd0) begin
      errors++;
      $display("FAIL bp_full_hold: ack0=%b count=%0d data=%h chan=%0d expected 0/8/40/0",
               ack_o[0], fifo_count, out_data, out_chan);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (fifo_count !== 4'd8 || ack_o[0] !== 1'b1 || out_data !== 8'h41 || out_chan !== 2'd1) begin
      errors++;
      $display("FAIL bp_push_pop_full: count=%0d ack0=%b data=%h chan=%0d expected 8/1/41/1",
               fifo_count, ack_o[0], out_data, out_chan);
    end
    async_req_i[0] = 1'b0;
    tick();
    tick();
    tick();
    for (int k = 0; k < DEPTH; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h41 + 8'(k) || out_chan !== 2'((k + 1) % NCH)) begin
        errors++;
        $display("FAIL bp_drain%0d: valid=%b data=%h chan=%0d expected 1/%h/%0d", k, out_valid,
                 out_data, out_chan, 8'h41 + 8'(k), (k + 1) % NCH);
      end
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (fifo_count !== 4'd0 || ack_o !== 4'b0) begin
      errors++;
      $display("FAIL bp_empty: count=%0d ack=%b expected 0/0000", fifo_count, ack_o);
    end
  endtask

  task automatic test_reset_mid();
    bit ok0, ok2;
    int k;
    do_reset();
    xfer(0, 8'h70, ok0);
    xfer(2, 8'h72, ok2);
    set_data(1, 8'h71);
    async_req_i[1] = 1'b1;
    k = 0;
    while (!ack_o[1] && k < 20) begin tick(); k++; end
    checks++;
    if (!ok0 || !ok2 || ack_o[1] !== 1'b1 || fifo_count !== 4'd3) begin
      errors++;
      $display("FAIL rm_setup: ok=%b%b ack1=%b count=%0d expected 11/1/3", ok0, ok2, ack_o[1],
               fifo_count);
    end
    #2 reset_i = 1'b1;
    #1;
    checks++;
    if (ack_o !== 4'b0 || out_valid !== 1'b0 || fifo_count !== 4'd0) begin
      errors++;
      $display("FAIL rm_async_clear: ack=%b valid=%b count=%0d expected 0/0/0", ack_o, out_valid,
               fifo_count);
    end
    tick();
    tick();
    reset_i = 1'b0;
    tick();
    tick();
    checks++;
    if (ack_o !== 4'b0) begin
      errors++;
      $display("FAIL rm_ack_early: ack=%b expected 0000", ack_o);
    end
    tick();
    checks++;
    if (ack_o !== 4'b0010 || fifo_count !== 4'd1 || out_chan !== 2'd1 || out_data !== 8'h71) begin
      errors++;
      $display("FAIL rm_reaccept: ack=%b count=%0d chan=%0d data=%h expected 0010/1/1/71", ack_o,
               fifo_count, out_chan, out_data);
    end
    async_req_i[1] = 1'b0;
    repeat (6) tick();
    checks++;
    if (ack_o !== 4'b0 || fifo_count !== 4'd1) begin
      errors++;
      $display("FAIL rm_once: ack=%b count=%0d expected 0000/1", ack_o, fifo_count);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_withdraw();
    bit ok;
    bit seen;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      xfer(i % 3, 8'h60 + 8'(i), ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL wd_fill%0d: handshake timed out, expected complete", i);
      end
    end
    seen = 1'b0;
    set_data(3, 8'hEE);
    async_req_i[3] = 1'b1;
    repeat (3) begin tick(); if (ack_o[3]) seen = 1'b1; end
    async_req_i[3] = 1'b0;
    repeat (12) begin tick(); if (ack_o[3]) seen = 1'b1; end
    checks++;
    if (seen || fifo_count !== 4'd8) begin
      errors++;
      $display("FAIL wd_no_ack: ack3_seen=%b count=%0d expected 0/8", seen, fifo_count);
    end
    for (int k = 0; k < DEPTH; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h60 + 8'(k) || out_chan !== 2'(k % 3)) begin
        errors++;
        $display("FAIL wd_drain%0d: valid=%b data=%h chan=%0d expected 1/%h/%0d", k, out_valid,
                 out_data, out_chan, 8'h60 + 8'(k), k % 3);
      end
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    tick();
    checks++;
    if (fifo_count !== 4'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL wd_no_write: count=%0d valid=%b expected 0/0", fifo_count, out_valid);
    end
  endtask

  // Randomized senders/consumer; scoreboard keeps per-channel order and occupancy.
  task automatic test_random();
    int         st[NCH];
    int         model_count;
    int         idx;
    bit         pop_pend;
    bit         draining;
    bit         busy;
    logic [3:0] ack_prev;
    logic [7:0] d;
    item_t      it;
    do_reset();
    exp_q.delete();
    for (int n = 0; n < NCH; n++) st[n] = 0;
    model_count = 0;
    pop_pend    = 1'b0;
    ack_prev    = '0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      draining = (cyc >= 3000);
      for (int n = 0; n < NCH; n++) begin
        if (ack_o[n] && !ack_prev[n]) begin
          model_count++;
          checks++;
          if (st[n] != 1) begin
            errors++;
            $display("FAIL rand_spurious_ack ch%0d: sender phase=%0d expected 1", n, st[n]);
          end
        end
      end
      if (pop_pend) model_count--;
      checks++;
      if (fifo_count !== model_count[3:0]) begin
        errors++;
        $display("FAIL rand_count cyc%0d: count=%0d expected %0d", cyc, fifo_count, model_count);
      end
      ack_prev = ack_o;
      for (int n = 0; n < NCH; n++) begin
        case (st[n])
          0: if (!draining && $urandom_range(0, 3) == 0) begin
            d = 8'($urandom);
            set_data(n, d);
            async_req_i[n] = 1'b1;
            it.ch = n[1:0];
            it.d  = d;
            exp_q.push_back(it);
            st[n] = 1;
          end
          1: if (ack_o[n]) begin
            async_req_i[n] = 1'b0;
            st[n] = 2;
          end
          default: if (!ack_o[n]) st[n] = 0;
        endcase
      end
      out_ready = ($urandom_range(0, 3) < ((cyc < 1500) ? 1 : 3));
      pop_pend  = out_valid && out_ready;
      if (pop_pend) begin
        idx = -1;
        for (int j = 0; j < exp_q.size(); j++) begin
          if (idx < 0 && exp_q[j].ch == out_chan) idx = j;
        end
        checks++;
        if (idx < 0) begin
          errors++;
          $display("FAIL rand_pop cyc%0d: chan=%0d data=%h expected a pending item", cyc, out_chan,
                   out_data);
        end else begin
          if (out_data !== exp_q[idx].d) begin
            errors++;
            $display("FAIL rand_data cyc%0d ch%0d: data=%h expected %h", cyc, out_chan, out_data,
                     exp_q[idx].d);
          end
          exp_q.delete(idx);
        end
      end
      busy = 1'b0;
      for (int n = 0; n < NCH; n++) if (st[n] != 0) busy = 1'b1;
      if (draining && !busy && exp_q.size() == 0 && !pop_pend) break;
      tick();
    end
    out_ready = 1'b0;
    busy = 1'b0;
    for (int n = 0; n < NCH; n++) if (st[n] != 0) busy = 1'b1;
    checks++;
    if (busy || exp_q.size() != 0 || fifo_count !== 4'd0) begin
      errors++;
      $display("FAIL rand_drain: busy=%b pending=%0d count=%0d expected 0/0/0", busy,
               exp_q.size(), fifo_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_withdraw();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
